dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe.sv | 95 +++++++++
 tb/tb_dff_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: elastic DEPTH-stage register pipeline with valid/ready handshake.
// Empty stages collapse, so a stalled output only stalls upstream stages once
// every stage between them and the output is occupied. out_data/out_valid come
// straight from the last stage's flops; in_ready is the only combinational path
// from out_ready back to the input side.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Next-state for every stage plus in_ready, walking from the output stage
  // back to stage 0 so each stage sees whether its successor moves this cycle.
  always_comb begin : next_state
    logic adv;
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a variable unassigned and no latch is inferred.
    valid_d  = valid_q;
    data_d   = data_q;
    in_ready = 1'b0;
    // The output stage advances (drops its word) whenever out_ready is high.
    adv = out_ready;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (!valid_q[k] || adv) begin
        valid_d[k] = valid_q[k-1];
        // Data only moves with a valid word; a bubble leaves the old payload.
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end
      end
      // Stage k-1 may advance exactly when stage k can take a new word.
      adv = !valid_q[k] || adv;
    end
    if (!valid_q[0] || adv) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = in_data;
      end
    end
    // A reset in progress overrides clr; with all stages empty stage 0 is free.
    in_ready = (!valid_q[0] || adv) && !(clr && rst_n);
    // Flush drops every word but leaves the payload registers untouched.
    if (clr) begin
      valid_d = '0;
      data_d  = data_q;
    end
  end

  // Stage registers; reset empties the pipe and loads RESET_VAL everywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      // NOTE: the payload registers are reset here because out_data must show
      // RESET_VAL during reset; this is a small register array, not a RAM.
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples its
      // predecessor's pre-edge value, independent of statement order.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CNT_W'(valid_q[k]);
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed scenarios plus random traffic, all compared against a
// word-queue model in which each in-flight word carries its stage position.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } word_t;

  word_t            q[$];        // in-flight words, oldest first
  logic [WIDTH-1:0] out_log[$];  // words the DUT handed downstream
  int               n_checks;
  int               n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stage 0 is free this cycle if, after the oldest word leaves (when it is at
  // the output and out_ready is high) and every word moves forward as far as
  // the word ahead of it allows, nothing lands in position 0.
  function automatic logic model_ready(input logic ordy, input logic c);
    int limit;
    int start;
    limit = DEPTH;
    start = 0;
    if (c) return 1'b0;
    if (q.size() == 0) return 1'b1;
    if (q[0].pos == DEPTH - 1 && ordy) start = 1;
    for (int i = start; i < q.size(); i++) begin
      limit = (q[i].pos + 1 < limit - 1) ? q[i].pos + 1 : limit - 1;
    end
    return limit >= 1;
  endfunction

  task automatic model_edge(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                            input logic c, input logic rdy);
    int limit;
    word_t w;
    if (c) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].pos == DEPTH - 1 && ordy) void'(q.pop_front());
      limit = DEPTH;
      for (int i = 0; i < q.size(); i++) begin
        q[i].pos = (q[i].pos + 1 < limit - 1) ? q[i].pos + 1 : limit - 1;
        limit = q[i].pos;
      end
      if (v && rdy) begin
        w.d = d;
        w.pos = 0;
        q.push_back(w);
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_ov;
    exp_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
    check("count", count, q.size());
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) check("out_data", out_data, q[0].d);
  endtask

  // One clock cycle: apply inputs, check in_ready, clock, check state.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                      input logic c, output logic acc);
    logic rdy;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    #1;
    rdy = model_ready(ordy, c);
    check("in_ready", in_ready, rdy);
    acc = v && in_ready;
    if (out_valid && ordy && !c) out_log.push_back(out_data);
    @(posedge clk);
    model_edge(v, d, ordy, c, rdy);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0, acc);
  endtask

  // Reset asserted between edges and held across one edge with input offered.
  task automatic pulse_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    clr      = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_count", count, 2'd0);
    check("rst_in_ready", in_ready, 1'b1);
    q.delete();
    @(posedge clk);
    #1;
    check("rst_hold_count", count, 2'd0);
    check("rst_hold_data", out_data, 8'h00);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    logic acc;
    logic acc2;
    int   idx;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Power-on reset, checked before the first clock edge.
    #3;
    check("por_out_valid", out_valid, 1'b0);
    check("por_out_data", out_data, 8'h00);
    check("por_count", count, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency: one word into an empty pipe with the sink always ready.
    step(1'b1, 8'hA5, 1'b1, 1'b0, acc);
    check("lat_accept", acc, 1'b1);
    idle(1, 1'b1);
    check("lat_n1_valid", out_valid, 1'b0);
    idle(1, 1'b1);
    check("lat_n2_valid", out_valid, 1'b1);
    check("lat_n2_data", out_data, 8'hA5);
    idle(1, 1'b1);
    check("lat_n3_valid", out_valid, 1'b0);

    // Back-pressure fill, then release and drain in order.
    out_log.delete();
    idx = 1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, idx[7:0], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_count", count, 2'd3);
    #1;
    check("bp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 12 && idx <= 5; i++) begin
      step(1'b1, idx[7:0], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    idle(4, 1'b1);
    check("bp_out_n", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) check("bp_order", out_log[i], i + 1);

    // Full streaming: fill, then ten words in and out back to back.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h0A + 8'(i), 1'b0, 1'b0, acc);
    out_log.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, acc);
      check("stream_acc", acc, 1'b1);
      check("stream_count", count, 2'd3);
    end
    check("stream_out_n", out_log.size(), 10);
    for (int i = 0; i < 3 && i < out_log.size(); i++) check("stream_head", out_log[i], 8'h0A + i);
    for (int i = 3; i < out_log.size(); i++) check("stream_body", out_log[i], 8'h10 + i - 3);
    idle(4, 1'b1);

    // Bubble collapse: one stalled word at the output, two pushed behind it.
    step(1'b1, 8'h2F, 1'b0, 1'b0, acc);
    idle(2, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0, acc);
    step(1'b1, 8'h21, 1'b0, 1'b0, acc2);
    check("bub_acc", {acc, acc2}, 2'b11);
    check("bub_count", count, 2'd3);
    check("bub_out_data", out_data, 8'h2F);
    check("bub_out_valid", out_valid, 1'b1);
    idle(4, 1'b1);

    // Flush with an input offered: nothing accepted, everything dropped.
    step(1'b1, 8'h31, 1'b0, 1'b0, acc);
    step(1'b1, 8'h32, 1'b0, 1'b0, acc);
    check("fl_pre_count", count, 2'd2);
    step(1'b1, 8'h33, 1'b0, 1'b1, acc);
    check("fl_acc", acc, 1'b0);
    check("fl_count", count, 2'd0);
    check("fl_out_valid", out_valid, 1'b0);
    idle(3, 1'b1);

    // Reset mid-stream discards in-flight words and restores RESET_VAL.
    step(1'b1, 8'h41, 1'b0, 1'b0, acc);
    step(1'b1, 8'h42, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    check("mr_pre_count", count, 2'd2);
    pulse_reset();
    idle(3, 1'b1);

    // Random traffic against the model, with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
